// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program as a stream of bytes, packs every four bytes into a
// 32-bit instruction word and writes the words into instruction memory at
// consecutive word addresses. The CPU fetch stage is held for the whole load,
// and a running mod-2^32 checksum of the written words is kept.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle load request, only looked at while idle
//   base_addr   in   byte address of the first word (bits [1:0] ignored)
//   word_count  in   number of words to load
//   byte_in     in   incoming program byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader can accept a byte (only while receiving)
//   imem_we     out  instruction-memory write strobe
//   imem_addr   out  word-aligned write byte address
//   imem_wdata  out  instruction word being written
//   cpu_hold    out  stalls fetch/PC while a load is in progress
//   busy        out  a load is in progress
//   done        out  one-cycle pulse when a load completes
//   err         out  one-cycle pulse when a request is rejected (too long)
//   checksum    out  sum of all words written by the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] base_q;
    logic [15:0] count_q;
    logic [15:0] index_q;
    logic [1:0]  byteCnt_q;
    logic [31:0] asm_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] checksum_q;

    logic [31:0] asm_d;
    logic [31:0] wrAddr_d;
    logic [15:0] index_d;
    logic        tooLarge;

    // Next assembly value for the byte on byte_in, the write address for the
    // current word, and the request bound check. The base is stored whole and
    // the sum is masked afterwards, which drops base bits [1:0] because the
    // word offset never touches them.
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            asm_d = {asm_q[23:0], byte_in};
        end else begin
            asm_d = {byte_in, asm_q[31:8]};
        end
        wrAddr_d = (base_q + {14'd0, index_q, 2'b00}) & 32'hFFFF_FFFC;
        index_d  = index_q + 16'd1;
        tooLarge = ({16'd0, word_count} > 32'(DEPTH_WORDS));
    end

    // Loader FSM. All outputs except byte_ready come from registers that are
    // set on the edge that enters the corresponding state, so imem_we, done
    // and busy line up exactly with WRITE, DONE and the non-idle states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= 32'd0;
            count_q    <= 16'd0;
            index_q    <= 16'd0;
            byteCnt_q  <= 2'd0;
            asm_q      <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            checksum_q <= 32'd0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count == 16'd0) begin
                            checksum_q <= 32'd0;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else if (tooLarge) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q     <= base_addr;
                            count_q    <= word_count;
                            index_q    <= 16'd0;
                            byteCnt_q  <= 2'd0;
                            checksum_q <= 32'd0;
                            busy_q     <= 1'b1;
                            state_q    <= RECV;
                        end
                    end
                end
                RECV: begin
                    // byte_ready is high throughout RECV, so valid alone
                    // decides whether a byte transfers on this edge.
                    if (byte_valid) begin
                        asm_q     <= asm_d;
                        byteCnt_q <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= wrAddr_d;
                            wdata_q <= asm_d;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    checksum_q <= checksum_q + wdata_q;
                    index_q    <= index_d;
                    if (index_d == count_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RECV;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready = (state_q == RECV);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign checksum   = checksum_q;

endmodule
